// File: rtl/ibutterfly_2_pipe.sv
// Inverse scaled radix-2 butterfly, twiddle (1+i)/sqrt(2), 2-stage valid/ready pipe.
// Recovers in1 = o1+o2 and in2 = (o1-o2)*(1+i)/sqrt(2) from a butterfly output pair.
// Ports:
//   clk, rst              clock, async active-high reset
//   in_valid/in_ready     input handshake for the (o1, o2) pair
//   o1_r/o1_i, o2_r/o2_i  butterfly outputs, W-bit signed
//   out_valid/out_ready   output handshake for the (x1, x2) pair
//   x1_r/x1_i, x2_r/x2_i  recovered inputs, W-bit signed, saturated
//   sat_flag, sat_clr     sticky saturation flag and its synchronous clear
module ibutterfly_2_pipe #(
  parameter int N    = 3,
  parameter int KINV = 181
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2**N-1:0]   o1_r,
  input  logic [2**N-1:0]   o1_i,
  input  logic [2**N-1:0]   o2_r,
  input  logic [2**N-1:0]   o2_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2**N-1:0]   x1_r,
  output logic [2**N-1:0]   x1_i,
  output logic [2**N-1:0]   x2_r,
  output logic [2**N-1:0]   x2_i,
  output logic              sat_flag,
  input  logic              sat_clr
);

  localparam int W  = 2**N;
  localparam int WS = W + 1;
  localparam int WT = W + 2;
  localparam int WP = WT + 9;

  localparam logic signed [WP-1:0] MAXV =
    WP'((2**(W-1)) - 1);
  localparam logic signed [WP-1:0] MINV = ~MAXV;
  localparam logic signed [8:0]    K    = 9'(KINV);

  typedef struct packed {
    logic [WS-1:0] s_r;
    logic [WS-1:0] s_i;
    logic [WS-1:0] d_r;
    logic [WS-1:0] d_i;
  } s1_t;

  s1_t          s1_q, s1_d;
  logic         s1_valid_q, s1_valid_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] x1_r_q, x1_r_d;
  logic [W-1:0] x1_i_q, x1_i_d;
  logic [W-1:0] x2_r_q, x2_r_d;
  logic [W-1:0] x2_i_q, x2_i_d;
  logic         sat_q, sat_d;

  logic         s2_adv;

  logic signed [WT-1:0] dr_x, di_x;
  logic signed [WT-1:0] t_r, t_i;
  logic signed [WP-1:0] p_r, p_i;
  // {clipped, value} per output
  logic [W:0]           c1r, c1i, c2r, c2i;

  function automatic logic signed [WS-1:0] sx(
    input logic [W-1:0] v
  );
    return $signed({v[W-1], v});
  endfunction

  function automatic logic signed [WP-1:0] wx(
    input logic [WS-1:0] v
  );
    return $signed({{(WP-WS){v[WS-1]}}, v});
  endfunction

  function automatic logic [W:0] sat_fn(
    input logic signed [WP-1:0] v
  );
    logic [W:0] r;
    unique case (1'b1)
      (v > MAXV): r = {1'b1, MAXV[W-1:0]};
      (v < MINV): r = {1'b1, MINV[W-1:0]};
      default:    r = {1'b0, v[W-1:0]};
    endcase
    return r;
  endfunction

  assign s2_adv    = !out_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_adv;
  assign out_valid = out_valid_q;
  assign x1_r      = x1_r_q;
  assign x1_i      = x1_i_q;
  assign x2_r      = x2_r_q;
  assign x2_i      = x2_i_q;
  assign sat_flag  = sat_q;

  // Twiddle product; >>>8 truncates toward -inf
  always_comb begin
    dr_x = $signed({s1_q.d_r[WS-1], s1_q.d_r});
    di_x = $signed({s1_q.d_i[WS-1], s1_q.d_i});
    t_r  = dr_x - di_x;
    t_i  = dr_x + di_x;
    p_r  = $signed({{9{t_r[WT-1]}}, t_r})
         * $signed({{WT{K[8]}}, K});
    p_i  = $signed({{9{t_i[WT-1]}}, t_i})
         * $signed({{WT{K[8]}}, K});
    c1r  = sat_fn(wx(s1_q.s_r));
    c1i  = sat_fn(wx(s1_q.s_i));
    c2r  = sat_fn(p_r >>> 8);
    c2i  = sat_fn(p_i >>> 8);
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d.s_r = sx(o1_r) + sx(o2_r);
        s1_d.s_i = sx(o1_i) + sx(o2_i);
        s1_d.d_r = sx(o1_r) - sx(o2_r);
        s1_d.d_i = sx(o1_i) - sx(o2_i);
      end
    end
  end

  // Clear is overridden by a same-edge saturation
  always_comb begin
    out_valid_d = out_valid_q;
    x1_r_d      = x1_r_q;
    x1_i_d      = x1_i_q;
    x2_r_d      = x2_r_q;
    x2_i_d      = x2_i_q;
    sat_d       = sat_q & ~sat_clr;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        x1_r_d = c1r[W-1:0];
        x1_i_d = c1i[W-1:0];
        x2_r_d = c2r[W-1:0];
        x2_i_d = c2i[W-1:0];
        if (c1r[W] | c1i[W] | c2r[W] | c2i[W])
          sat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      x1_r_q      <= '0;
      x1_i_q      <= '0;
      x2_r_q      <= '0;
      x2_i_q      <= '0;
      sat_q       <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      x1_r_q      <= x1_r_d;
      x1_i_q      <= x1_i_d;
      x2_r_q      <= x2_r_d;
      x2_i_q      <= x2_i_d;
      sat_q       <= sat_d;
    end
  end

endmodule

// File: tb/tb_ibutterfly_2_pipe.sv
// Testbench for ibutterfly_2_pipe (N=3): vector table,
// hand-written stall/reset sequences, randomized scoreboard run.
module tb_ibutterfly_2_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] o1_r = '0, o1_i = '0;
  logic [7:0] o2_r = '0, o2_i = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] x1_r, x1_i, x2_r, x2_i;
  logic       sat_flag;
  logic       sat_clr = 1'b0;

  ibutterfly_2_pipe #(.N(3), .KINV(181)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .o1_r(o1_r), .o1_i(o1_i),
    .o2_r(o2_r), .o2_i(o2_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .x1_r(x1_r), .x1_i(x1_i),
    .x2_r(x2_r), .x2_i(x2_i),
    .sat_flag(sat_flag), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x1r, x1i, x2r, x2i;
    bit clip;
  } res_t;

  typedef struct {
    int o1r, o1i, o2r, o2i;
    int x1r, x1i, x2r, x2i;
    bit sat;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   n_pop = 0;
  res_t sb[$];
  bit   exp_sat = 1'b0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic int clamp8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int floor256(input int p);
    int q;
    q = p / 256;
    if (p < 0 && q * 256 != p) q = q - 1;
    return q;
  endfunction

  function automatic res_t model(input int ar, input int ai,
                                 input int br, input int bi);
    res_t r;
    int s_r, s_i, d_r, d_i, t_r, t_i, y_r, y_i;
    s_r = ar + br;
    s_i = ai + bi;
    d_r = ar - br;
    d_i = ai - bi;
    t_r = d_r - d_i;
    t_i = d_r + d_i;
    y_r = floor256(t_r * 181);
    y_i = floor256(t_i * 181);
    r.x1r  = clamp8(s_r);
    r.x1i  = clamp8(s_i);
    r.x2r  = clamp8(y_r);
    r.x2i  = clamp8(y_i);
    r.clip = (r.x1r != s_r) || (r.x1i != s_i) ||
             (r.x2r != y_r) || (r.x2i != y_i);
    return r;
  endfunction

  function automatic int sv8(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(255)) - 128;
  endfunction

  task automatic drive(input int ar, input int ai,
                       input int br, input int bi);
    o1_r = 8'(ar);
    o1_i = 8'(ai);
    o2_r = 8'(br);
    o2_i = 8'(bi);
  endtask

  task automatic chk_out(input string nm, input res_t r);
    chk({nm, "_x1_r"}, sv8(x1_r), r.x1r);
    chk({nm, "_x1_i"}, sv8(x1_i), r.x1i);
    chk({nm, "_x2_r"}, sv8(x2_r), r.x2r);
    chk({nm, "_x2_i"}, sv8(x2_i), r.x2i);
  endtask

  // One cycle of streaming traffic checked against the
  // scoreboard; occupancy of the queue gives in_ready.
  task automatic step(input bit iv, input int ar,
                      input int ai, input int br,
                      input int bi, input bit ordy,
                      output bit acc);
    @(negedge clk);
    in_valid  = iv;
    drive(ar, ai, br, bi);
    out_ready = ordy;
    sat_clr   = 1'b0;
    #1;
    chk("in_ready", int'(in_ready),
        int'(sb.size() < 2 || ordy));
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        chk_out("stream", sb[0]);
        chk("stream_sat", int'(sat_flag),
            int'(exp_sat | sb[0].clip));
        if (ordy) begin
          exp_sat = exp_sat | sb[0].clip;
          void'(sb.pop_front());
          n_pop++;
        end
      end
    end else begin
      chk("idle_sat", int'(sat_flag), int'(exp_sat));
    end
    acc = iv && in_ready;
    if (acc) sb.push_back(model(ar, ai, br, bi));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    res_t r;
    bit   acc;
    bit   saw_low;
    int   k, pend, c, base;

    tbl[0] = '{5, 0, 5, 0, 10, 0, 0, 0, 1'b0};
    tbl[1] = '{20, 0, -20, 0, 0, 0, 28, 28, 1'b0};
    tbl[2] = '{0, 0, 0, 10, 0, 10, 7, -8, 1'b0};
    tbl[3] = '{127, -128, 127, -128,
               127, -128, 0, 0, 1'b1};
    tbl[4] = '{-128, 127, 127, -128,
               -1, -1, -128, 0, 1'b1};
    tbl[5] = '{100, 50, 30, -20, 127, 30, 0, 98, 1'b1};
    tbl[6] = '{-3, 7, 2, -1, -1, 6, -10, 2, 1'b0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_sat", int'(sat_flag), 0);
    chk("rst_x1_r", sv8(x1_r), 0);
    chk("rst_x2_i", sv8(x2_i), 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      drive(tbl[i].o1r, tbl[i].o1i, tbl[i].o2r, tbl[i].o2i);
      @(negedge clk);
      in_valid = 1'b0;
      k = 0;
      do begin
        @(negedge clk);
        #1;
        k++;
      end while (!out_valid && k < 8);
      chk("tbl_latency", k, 1);
      r.x1r  = tbl[i].x1r;
      r.x1i  = tbl[i].x1i;
      r.x2r  = tbl[i].x2r;
      r.x2i  = tbl[i].x2i;
      r.clip = tbl[i].sat;
      chk_out("tbl", r);
      chk("tbl_sat", int'(sat_flag), int'(tbl[i].sat));
      @(negedge clk);
      sat_clr = 1'b1;
      @(negedge clk);
      sat_clr = 1'b0;
      #1;
      chk("tbl_sat_clr", int'(sat_flag), 0);
    end

    // clear on the same edge as a saturating load
    @(negedge clk);
    in_valid = 1'b1;
    drive(127, -128, 127, -128);
    @(negedge clk);
    in_valid = 1'b0;
    sat_clr  = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    #1;
    chk("set_wins_sat", int'(sat_flag), 1);
    chk("set_wins_valid", int'(out_valid), 1);
    @(negedge clk);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    #1;
    chk("set_wins_clr", int'(sat_flag), 0);
    exp_sat = 1'b0;

    // six pairs with downstream stalled in cycles 3..6
    pend    = 6;
    c       = 0;
    saw_low = 1'b0;
    base    = n_pop;
    while ((pend > 0 || sb.size() > 0) && c < 40) begin
      c++;
      step(pend > 0, rnd8(), rnd8(), rnd8(), rnd8(),
           !(c >= 3 && c <= 6), acc);
      if (acc) pend--;
      if (pend > 0 && !in_ready) saw_low = 1'b1;
    end
    chk("stall_pairs_out", n_pop - base, 6);
    chk("stall_in_ready_low", int'(saw_low), 1);
    chk("stall_drained", sb.size(), 0);

    // reset with two pairs in flight
    step(1'b1, 50, 10, 20, -5, 1'b1, acc);
    step(1'b1, 1, 2, 3, 4, 1'b1, acc);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("rst_mid_pre_valid", int'(out_valid), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", int'(out_valid), 0);
    chk("rst_mid_x1_r", sv8(x1_r), 0);
    chk("rst_mid_x1_i", sv8(x1_i), 0);
    chk("rst_mid_x2_r", sv8(x2_r), 0);
    chk("rst_mid_x2_i", sv8(x2_i), 0);
    sb.delete();
    exp_sat = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_valid", int'(out_valid), 0);
    @(negedge clk);
    in_valid = 1'b1;
    drive(9, 9, 1, 1);
    r = model(9, 9, 1, 1);
    #1;
    chk("rel_in_ready", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("rel_lat1_valid", int'(out_valid), 0);
    @(negedge clk);
    #1;
    chk("rel_lat2_valid", int'(out_valid), 1);
    chk_out("rel", r);

    // randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(3) != 0, rnd8(), rnd8(),
           rnd8(), rnd8(), $urandom_range(3) != 0, acc);
    end
    c = 0;
    while (sb.size() > 0 && c < 20) begin
      c++;
      step(1'b0, 0, 0, 0, 0, 1'b1, acc);
    end
    chk("rand_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
